// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// ---------------------------------------------------------------------------
// Main control FSM for the multicycle RV32I core. It sequences the shared ALU,
// the unified memory port, the instruction register and the register file
// through FETCH / DECODE / EXECUTE / WRITEBACK style states. ALUOp feeds the
// existing ALU decoder, which still produces ALUControl.
//
// Supported opcodes: lw, sw, R-type, I-type ALU, beq, jal. Any other opcode
// seen in DECODE sends the FSM to TRAP. TRAP is absorbing until reset.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   op            opcode from the instruction register (Instr[6:0])
//   zero          ALU zero flag (same cycle, used in BEQ)
//   mem_ready     unified memory completes its access this cycle
//   PCWrite       PC enable = PCUpdate | (Branch & zero)
//   AdrSrc        memory address select (0 = PC, 1 = Result)
//   MemWrite      memory write strobe
//   IRWrite       instruction register / OldPC enable
//   ResultSrc     00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA       00 PC, 01 OldPC, 10 rs1 data
//   ALUSrcB       00 rs2 data, 01 ImmExt, 10 constant 4
//   ALUOp         00 add, 01 sub, 10 funct-decoded
//   ImmSrc        immediate format, decoded combinationally from op
//   RegWrite      register file write enable
//   instr_done    one-cycle pulse when an instruction retires
//   illegal_instr sticky flag, set when an unsupported opcode is decoded
//   dbg_state     current state encoding
//
// Handshake: mem_ready is a per-cycle completion qualifier. A state that owns
// the memory port (FETCH, MEMREAD, MEMWRITE) keeps presenting its request
// every cycle and leaves only in a cycle where mem_ready=1; the side effects
// of completion (IRWrite/PC update in FETCH, instr_done in MEMWRITE) are
// asserted only in that cycle.
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               instr_done,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 0,
    FETCH    = 1,
    DECODE   = 2,
    MEMADR   = 3,
    MEMREAD  = 4,
    MEMWB    = 5,
    MEMWRITE = 6,
    EXECUTER = 7,
    EXECUTEI = 8,
    ALUWB    = 9,
    BEQ      = 10,
    JAL      = 11,
    TRAP     = 12
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   illegal_q;
  logic   pc_update;
  logic   branch;

  // Next-state logic. Unused encodings (13-15) fall into the default arm and
  // therefore behave exactly like IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  // State register and sticky illegal flag. The flag is loaded on the same
  // edge that enters TRAP, so it is already high in the first TRAP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == TRAP) illegal_q <= 1'b1;
    end
  end

  // Control decode from the current state. mem_ready only qualifies the
  // completion side effects; every other output is a pure function of state.
  always_comb begin
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      DECODE: begin
        // Branch/jump target OldPC + imm parked in ALUOut for BEQ.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        // Strobe held every cycle until the memory accepts it.
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        // ALU compares rs1 - rs2 while PC loads the DECODE target from ALUOut.
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      JAL: begin
        // PC <- ALUOut (target), ALU computes OldPC + 4 for the link write.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite       = pc_update | (branch & zero);
  assign illegal_instr = illegal_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_ILL = 7'b1110011;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  // Packed output bundle:
  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
  //  ImmSrc, RegWrite, instr_done, illegal_instr}
  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] o(input int pcw, input int adr, input int mw,
                                    input int irw, input int rs, input int sa,
                                    input int sb, input int aop, input int imm,
                                    input int rw, input int done, input int ill);
    logic [16:0] r;
    r = {pcw[0], adr[0], mw[0], irw[0], rs[1:0], sa[1:0], sb[1:0], aop[1:0],
         imm[1:0], rw[0], done[0], ill[0]};
    return r;
  endfunction

  function automatic logic [16:0] dut_outs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ALUOp, ImmSrc, RegWrite, instr_done, illegal_instr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [6:0] vop, input logic vz, input logic vmr,
                     input int vst, input logic [16:0] vexp);
    vec_t v;
    v.op = vop; v.zero = vz; v.mr = vmr; v.st = vst[3:0]; v.exp = vexp;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drive inputs, check mid-cycle, advance.
  task automatic apply_row(input int idx);
    op        = vecs[idx].op;
    zero      = vecs[idx].zero;
    mem_ready = vecs[idx].mr;
    @(negedge clk);
    chk($sformatf("row%0d_state", idx), 32'(dbg_state), 32'(vecs[idx].st));
    chk($sformatf("row%0d_outs", idx), 32'(dut_outs()), 32'(vecs[idx].exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- vector table: one row per cycle, starting at the IDLE cycle ----
    //                                pcw adr mw irw rs sa sb aop imm rw dn il
    add(OP_LW,  0, 1,  0, o(0,0,0,0, 0,0,0,0, 0, 0,0,0)); // IDLE
    // lw, no stalls: 1,2,3,4,5
    add(OP_LW,  0, 1,  1, o(1,0,0,1, 2,0,2,0, 0, 0,0,0));
    add(OP_LW,  0, 1,  2, o(0,0,0,0, 0,1,1,0, 0, 0,0,0));
    add(OP_LW,  0, 1,  3, o(0,0,0,0, 0,2,1,0, 0, 0,0,0));
    add(OP_LW,  0, 1,  4, o(0,1,0,0, 0,0,0,0, 0, 0,0,0));
    add(OP_LW,  0, 1,  5, o(0,0,0,0, 1,0,0,0, 0, 1,1,0));
    // sw: one FETCH stall, two MEMWRITE stalls
    add(OP_SW,  0, 0,  1, o(0,0,0,0, 2,0,2,0, 1, 0,0,0));
    add(OP_SW,  0, 1,  1, o(1,0,0,1, 2,0,2,0, 1, 0,0,0));
    add(OP_SW,  0, 0,  2, o(0,0,0,0, 0,1,1,0, 1, 0,0,0));
    add(OP_SW,  0, 0,  3, o(0,0,0,0, 0,2,1,0, 1, 0,0,0));
    add(OP_SW,  0, 0,  6, o(0,1,1,0, 0,0,0,0, 1, 0,0,0));
    add(OP_SW,  0, 0,  6, o(0,1,1,0, 0,0,0,0, 1, 0,0,0));
    add(OP_SW,  0, 1,  6, o(0,1,1,0, 0,0,0,0, 1, 0,1,0));
    // beq taken
    add(OP_BEQ, 0, 1,  1, o(1,0,0,1, 2,0,2,0, 2, 0,0,0));
    add(OP_BEQ, 0, 1,  2, o(0,0,0,0, 0,1,1,0, 2, 0,0,0));
    add(OP_BEQ, 1, 1, 10, o(1,0,0,0, 0,2,0,1, 2, 0,1,0));
    // beq not taken, mem_ready low in BEQ must not matter
    add(OP_BEQ, 1, 1,  1, o(1,0,0,1, 2,0,2,0, 2, 0,0,0));
    add(OP_BEQ, 1, 1,  2, o(0,0,0,0, 0,1,1,0, 2, 0,0,0));
    add(OP_BEQ, 0, 0, 10, o(0,0,0,0, 0,2,0,1, 2, 0,1,0));
    // R-type
    add(OP_R,   0, 1,  1, o(1,0,0,1, 2,0,2,0, 0, 0,0,0));
    add(OP_R,   0, 1,  2, o(0,0,0,0, 0,1,1,0, 0, 0,0,0));
    add(OP_R,   0, 1,  7, o(0,0,0,0, 0,2,0,2, 0, 0,0,0));
    add(OP_R,   0, 1,  9, o(0,0,0,0, 0,0,0,0, 0, 1,1,0));
    // addi
    add(OP_I,   0, 1,  1, o(1,0,0,1, 2,0,2,0, 0, 0,0,0));
    add(OP_I,   0, 1,  2, o(0,0,0,0, 0,1,1,0, 0, 0,0,0));
    add(OP_I,   0, 1,  8, o(0,0,0,0, 0,2,1,2, 0, 0,0,0));
    add(OP_I,   0, 1,  9, o(0,0,0,0, 0,0,0,0, 0, 1,1,0));
    // jal, mem_ready low in JAL still updates PC
    add(OP_JAL, 0, 1,  1, o(1,0,0,1, 2,0,2,0, 3, 0,0,0));
    add(OP_JAL, 0, 1,  2, o(0,0,0,0, 0,1,1,0, 3, 0,0,0));
    add(OP_JAL, 0, 0, 11, o(1,0,0,0, 0,1,2,0, 3, 0,0,0));
    add(OP_JAL, 0, 1,  9, o(0,0,0,0, 0,0,0,0, 3, 1,1,0));
    // lw with one MEMREAD stall
    add(OP_LW,  0, 1,  1, o(1,0,0,1, 2,0,2,0, 0, 0,0,0));
    add(OP_LW,  0, 1,  2, o(0,0,0,0, 0,1,1,0, 0, 0,0,0));
    add(OP_LW,  0, 1,  3, o(0,0,0,0, 0,2,1,0, 0, 0,0,0));
    add(OP_LW,  0, 0,  4, o(0,1,0,0, 0,0,0,0, 0, 0,0,0));
    add(OP_LW,  0, 1,  4, o(0,1,0,0, 0,0,0,0, 0, 0,0,0));
    add(OP_LW,  0, 1,  5, o(0,0,0,0, 1,0,0,0, 0, 1,1,0));
    // illegal opcode
    add(OP_ILL, 0, 1,  1, o(1,0,0,1, 2,0,2,0, 0, 0,0,0));
    add(OP_ILL, 0, 1,  2, o(0,0,0,0, 0,1,1,0, 0, 0,0,0));
    add(OP_ILL, 0, 1, 12, o(0,0,0,0, 0,0,0,0, 0, 0,0,1));

    // ---- reset: 3 cycles low with mem_ready=1 ----
    reset_n = 1'b0; op = OP_LW; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset%0d_state", i), 32'(dbg_state), 32'd0);
      chk($sformatf("reset%0d_outs", i), 32'(dut_outs()), 32'd0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;

    // ---- table-driven run ----
    for (int i = 0; i < vecs.size(); i++) apply_row(i);

    // ---- TRAP hold for 20 cycles with random qualifiers ----
    op = OP_ILL;
    for (int i = 0; i < 20; i++) begin
      zero      = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trap_state", 32'(dbg_state), 32'd12);
      chk("trap_illegal", 32'(illegal_instr), 32'd1);
      chk("trap_writes", 32'({PCWrite, MemWrite, IRWrite, RegWrite, instr_done}), 32'd0);
      @(posedge clk);
      #1;
    end

    // ---- async reset mid-TRAP, no clock edge ----
    #1 reset_n = 1'b0;
    #1;
    chk("trap_rst_state", 32'(dbg_state), 32'd0);
    chk("trap_rst_illegal", 32'(illegal_instr), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    mem_ready = 1'b1; op = OP_SW; zero = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(dbg_state), 32'd0);
    @(negedge clk);
    chk("post_rst_fetch", 32'(dbg_state), 32'd1);
    chk("post_rst_irwrite", 32'({IRWrite, PCWrite}), 32'd3);

    // ---- reset mid-sw aborts the pending store ----
    @(negedge clk);                           // DECODE
    @(negedge clk);                           // MEMADR
    mem_ready = 1'b0;
    @(negedge clk);                           // MEMWRITE, stalled
    chk("abort_pre_state", 32'(dbg_state), 32'd6);
    chk("abort_pre_memwrite", 32'(MemWrite), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    chk("abort_hold_outs", 32'(dut_outs()), 32'(o(0,0,0,0, 0,0,0,0, 1, 0,0,0)));

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle variant of the RV32I core. It replaces the single-cycle main decoder. It sequences the shared ALU, memory port, instruction register and register file across FETCH/DECODE/EXECUTE/WRITEBACK states. It drives ALUOp into the existing ALU decoder, which still produces ALUControl. Supported opcodes: lw, sw, R-type, I-type ALU, beq, jal. All others trap.

Parameters:
STATE_W, 4, width of the state register and of the dbg_state output.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  7  opcode of the instruction register (Instr[6:0])
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  unified memory completes the access this cycle
PCWrite  out  1  PC register enable; equals PCUpdate | (Branch & zero)
AdrSrc  out  1  memory address select (0 = PC, 1 = Result)
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register / OldPC enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 data
ALUSrcB  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
ALUOp  out  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded
ImmSrc  out  2  combinational from op: 0100011→01, 1100011→10, 1101111→11, else 00
RegWrite  out  1  register file write enable
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_instr  out  1  sticky; set on an unsupported opcode
dbg_state  out  STATE_W  current state encoding

Behaviour:
- Moore FSM, except for the mem_ready/zero qualifiers listed below. Encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTER=7, EXECUTEI=8, ALUWB=9, BEQ=10, JAL=11, TRAP=12. Encodings 13-15 behave as IDLE.
- Reset (async, reset_n=0): state←IDLE, illegal_instr←0. In IDLE every output is 0 except ImmSrc, which stays combinational from op. IDLE→FETCH unconditionally on the next edge. Reset mid-instruction aborts it with no further writes.
- Any control output not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only while mem_ready=1.
  - Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - else → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready=1, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00.
  - MemWrite=1 every cycle in this state; the memory must tolerate a repeated strobe.
  - Hold until mem_ready=1. In that cycle instr_done=1; → FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - PCWrite=zero; PC takes ALUOut (the target computed in DECODE).
  - instr_done=1. → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. → ALUWB (rd←OldPC+4).
- TRAP: illegal_instr=1. All write enables are 0. TRAP is absorbing; only reset exits.
- Latency from FETCH entry, with mem_ready=1 throughout:
  - lw 5 cycles; sw 4; R/I 4; beq 3; jal 4.
  - Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- PCWrite is never asserted in a cycle where mem_ready=0 unless the state is BEQ or JAL.
- instr_done is never asserted in two consecutive cycles.

Test Plan:
- Reset: hold reset_n=0 3 cycles with mem_ready=1 → dbg_state=0, all control outputs 0. Release → one IDLE cycle, then FETCH with IRWrite=1, PCWrite=1.
- lw, op=0000011, mem_ready=1 → states 1,2,3,4,5,1. RegWrite=1 and ResultSrc=01 only in state 5; instr_done pulses once.
- sw with mem_ready low 2 cycles in MEMWRITE → MemWrite=1 for 3 cycles, instr_done in the 3rd, RegWrite=0 throughout.
- beq with zero=1, then zero=0 → PCWrite=1 / PCWrite=0 in BEQ. ALUOp=01 in BEQ, ALUSrcB=00.
- R-type (0110011) vs addi (0010011) → EXECUTER ALUSrcB=00 vs EXECUTEI ALUSrcB=01, both ALUOp=10, then ALUWB RegWrite=1. ImmSrc=00.
- Illegal op=1110011 → DECODE→TRAP, illegal_instr=1 stays set for 20 cycles with no writes. Asserting reset_n=0 mid-TRAP clears it immediately, asynchronously.
